// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; misses stall while a dirty victim is written back and the line is refilled word by word.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic [31:0] miss_cnt,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ready
);

  localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int NUM_SETS     = 1 << SET_ADDR_LEN;
  localparam int NUM_WORDS    = 1 << LINE_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;
  localparam logic [LINE_ADDR_LEN-1:0] FIRST_WORD = '0;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  state_t                   state;
  logic [31:0]              data_array [NUM_SETS][NUM_WORDS];
  logic [TAG_ADDR_LEN-1:0]  tag_array  [NUM_SETS];
  logic [NUM_SETS-1:0]      valid;
  logic [NUM_SETS-1:0]      dirty;
  logic [LINE_ADDR_LEN-1:0] counter;
  logic [LINE_ADDR_LEN-1:0] counter_nxt;
  logic [SET_ADDR_LEN-1:0]  cur_set;
  logic [TAG_ADDR_LEN-1:0]  req_tag;
  logic [TAG_ADDR_LEN-1:0]  victim_tag;

  logic [LINE_ADDR_LEN-1:0] word;
  logic [SET_ADDR_LEN-1:0]  set;
  logic [TAG_ADDR_LEN-1:0]  tag;
  logic                     req;
  logic                     hit;
  logic                     unused_addr_bits;

  assign word             = addr[LINE_ADDR_LEN+1:2];
  assign set              = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign tag              = addr[31:SET_ADDR_LEN+LINE_ADDR_LEN+2];
  assign unused_addr_bits = ^addr[1:0];

  assign req         = rd_req | wr_req;
  assign hit         = (state == IDLE) && valid[set] && (tag_array[set] == tag);
  assign miss        = req && !hit;
  assign rd_data     = hit ? data_array[set][word] : 32'd0;
  assign counter_nxt = counter + 1'b1;

  // NOTE: data and tag storage carry no reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (hit && wr_req)
      data_array[set][word] <= wr_data;
    if (state == SWAP_IN && mem_ready)
      data_array[cur_set][counter] <= mem_rd_data;
    if (state == SWAP_IN_OK)
      tag_array[cur_set] <= req_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      counter     <= '0;
      cur_set     <= '0;
      req_tag     <= '0;
      victim_tag  <= '0;
      miss_cnt    <= '0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            cur_set    <= set;
            req_tag    <= tag;
            victim_tag <= tag_array[set];
            counter    <= '0;
            miss_cnt   <= miss_cnt + 32'd1;
            // Outputs are registered, so the first word's address is set up on the way into the transfer state.
            if (valid[set] && dirty[set]) begin
              state       <= SWAP_OUT;
              mem_wr_req  <= 1'b1;
              mem_addr    <= {tag_array[set], set, FIRST_WORD, 2'b00};
              mem_wr_data <= data_array[set][0];
            end else begin
              state      <= SWAP_IN;
              mem_rd_req <= 1'b1;
              mem_addr   <= {tag, set, FIRST_WORD, 2'b00};
            end
          end else if (hit && wr_req) begin
            dirty[set] <= 1'b1;
          end
        end
        SWAP_OUT: begin
          if (mem_ready) begin
            counter <= counter_nxt;
            if (counter == LAST_WORD) begin
              state      <= SWAP_IN;
              mem_wr_req <= 1'b0;
              mem_rd_req <= 1'b1;
              mem_addr   <= {req_tag, cur_set, FIRST_WORD, 2'b00};
            end else begin
              mem_addr    <= {victim_tag, cur_set, counter_nxt, 2'b00};
              mem_wr_data <= data_array[cur_set][counter_nxt];
            end
          end
        end
        SWAP_IN: begin
          if (mem_ready) begin
            counter <= counter_nxt;
            if (counter == LAST_WORD) begin
              state      <= SWAP_IN_OK;
              mem_rd_req <= 1'b0;
            end else begin
              mem_addr <= {req_tag, cur_set, counter_nxt, 2'b00};
            end
          end
        end
        SWAP_IN_OK: begin
          valid[cur_set] <= 1'b1;
          dirty[cur_set] <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a word-level memory model plus a reference cache
// (per-set valid/tag/dirty and a logical memory image) predicts hits, transfers, latency and data.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  localparam int WORDS     = 8;
  localparam int SETS      = 4;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        miss;
  logic [31:0] miss_cnt;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data = '0;
  logic        mem_ready = 1'b0;

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .miss_cnt(miss_cnt),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       xlog[$];
  xfer_t       exp_q[$];
  logic [31:0] phys    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  bit          rv   [SETS];
  bit          rdty [SETS];
  logic [24:0] rtag [SETS];
  int          ref_miss_cnt = 0;
  int          lat_target = 3;
  int          lat = 0;
  int          both_req_seen = 0;
  int          tests = 0;
  int          fails = 0;

  // Memory: answers each word lat_target cycles after it is requested (1 = ready every cycle).
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      lat = 0;
    end else begin
      if (mem_rd_req && mem_wr_req) both_req_seen++;
      if (mem_ready && lat_target > 1) begin
        mem_ready = 1'b0;
        lat = (mem_rd_req || mem_wr_req) ? 1 : 0;
      end else if (mem_rd_req || mem_wr_req) begin
        lat++;
        if (lat >= lat_target) begin
          mem_ready = 1'b1;
          if (mem_wr_req) begin
            phys[mem_addr[11:2]] = mem_wr_data;
            xlog.push_back('{1'b1, mem_addr, mem_wr_data});
          end else begin
            mem_rd_data = phys[mem_addr[11:2]];
            xlog.push_back('{1'b0, mem_addr, phys[mem_addr[11:2]]});
          end
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        mem_ready = 1'b0;
        lat = 0;
      end
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transfers a miss on (s, tg) must produce: optional victim writeback, then the refill.
  function automatic void build_expected(input logic [1:0] s, input logic [24:0] tg);
    exp_q.delete();
    if (rv[s] && rdty[s])
      for (int w = 0; w < WORDS; w++) begin
        logic [31:0] ea;
        ea = {rtag[s], s, 3'(w), 2'b00};
        exp_q.push_back('{1'b1, ea, ref_mem[ea[11:2]]});
      end
    for (int w = 0; w < WORDS; w++) begin
      logic [31:0] ea;
      ea = {tg, s, 3'(w), 2'b00};
      exp_q.push_back('{1'b0, ea, ref_mem[ea[11:2]]});
    end
  endfunction

  // Entered just after a negedge; drives one access and follows it through any refill.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input string name);
    logic [1:0]  s;
    logic [24:0] tg;
    int          idx;
    bit          exp_hit;
    bit          was_dirty;
    int          cycles;
    int          exp_cycles;
    int          bad;
    s = a[6:5];
    tg = a[31:7];
    idx = int'(a[11:2]);
    exp_hit = rv[s] && (rtag[s] == tg);
    was_dirty = rv[s] && rdty[s];
    build_expected(s, tg);
    xlog.delete();
    rd_req = rd; wr_req = wr; addr = a; wr_data = wd;
    #1;
    tests++;
    if (miss !== !exp_hit) begin
      fails++;
      $display("FAIL %s miss_flag: got %b expected %b", name, miss, !exp_hit);
    end
    if (!exp_hit) begin
      cycles = 1;
      forever begin
        @(negedge clk); #1;
        if (miss !== 1'b1 || cycles >= 400) break;
        cycles++;
      end
      exp_cycles = (was_dirty ? 2 * WORDS * lat_target : WORDS * lat_target) + 2;
      tests++;
      if (cycles != exp_cycles) begin
        fails++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", name, cycles, exp_cycles);
      end
      ref_miss_cnt++;
      rv[s] = 1'b1; rtag[s] = tg; rdty[s] = 1'b0;
      tests++;
      bad = -1;
      if (xlog.size() == exp_q.size())
        for (int i = 0; i < xlog.size(); i++)
          if (bad < 0 && (xlog[i].wr !== exp_q[i].wr || xlog[i].a !== exp_q[i].a || xlog[i].d !== exp_q[i].d))
            bad = i;
      if (xlog.size() != exp_q.size()) begin
        fails++;
        $display("FAIL %s xfer_count: got %0d expected %0d", name, xlog.size(), exp_q.size());
      end else if (bad >= 0) begin
        fails++;
        $display("FAIL %s xfer[%0d]: got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h", name, bad,
                 xlog[bad].wr, xlog[bad].a, xlog[bad].d, exp_q[bad].wr, exp_q[bad].a, exp_q[bad].d);
      end
      tests++;
      if (miss_cnt !== 32'(ref_miss_cnt)) begin
        fails++;
        $display("FAIL %s miss_cnt: got %0d expected %0d", name, miss_cnt, ref_miss_cnt);
      end
    end
    if (rd && !wr) begin
      tests++;
      if (miss !== 1'b0 || rd_data !== ref_mem[idx]) begin
        fails++;
        $display("FAIL %s load_data: got miss=%b data=%h expected miss=0 data=%h", name, miss, rd_data, ref_mem[idx]);
      end
    end
    if (wr) begin
      ref_mem[idx] = wd;
      rdty[s] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic reset_reference();
    for (int i = 0; i < SETS; i++) begin
      rv[i] = 1'b0; rdty[i] = 1'b0; rtag[i] = '0;
    end
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = phys[i];
    ref_miss_cnt = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < MEM_WORDS; i++) begin
      phys[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0009_E377);
    end
    reset_reference();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (miss_cnt !== 32'd0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0 ||
        mem_addr !== 32'd0 || mem_wr_data !== 32'd0 || miss !== 1'b0 || rd_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: got cnt=%h rd=%b wr=%b addr=%h wdata=%h miss=%b rdata=%h expected all zero",
               miss_cnt, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, miss, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_refill_and_hit();
    do_access(1'b1, 1'b0, 32'h0000_0040, '0, "first_refill");
    do_access(1'b1, 1'b0, 32'h0000_0044, '0, "load_hit");
    tests++;
    if (xlog.size() != 0 || miss_cnt !== 32'd1) begin
      fails++;
      $display("FAIL hit_no_traffic: got xfers=%0d cnt=%0d expected xfers=0 cnt=1", xlog.size(), miss_cnt);
    end
  endtask

  task automatic test_dirty_evict();
    bit found;
    do_access(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, "store_hit");
    do_access(1'b1, 1'b0, 32'h0000_0148, '0, "dirty_evict");
    found = 1'b0;
    foreach (xlog[i]) if (xlog[i].wr && xlog[i].a == 32'h48 && xlog[i].d == 32'hDEAD_BEEF) found = 1'b1;
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL writeback_store: got no write of deadbeef to 00000048 expected one");
    end
  endtask

  task automatic test_clean_evict();
    int writes;
    do_access(1'b1, 1'b0, 32'h0000_0248, '0, "clean_evict");
    writes = 0;
    foreach (xlog[i]) if (xlog[i].wr) writes++;
    tests++;
    if (writes != 0) begin
      fails++;
      $display("FAIL clean_no_writeback: got %0d writes expected 0", writes);
    end
  endtask

  task automatic test_read_write_both();
    bit found;
    do_access(1'b1, 1'b1, 32'h0000_024C, 32'h1234_5678, "rd_wr_both");
    do_access(1'b1, 1'b0, 32'h0000_004C, '0, "evict_after_both");
    found = 1'b0;
    foreach (xlog[i]) if (xlog[i].wr && xlog[i].a == 32'h24C && xlog[i].d == 32'h1234_5678) found = 1'b1;
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL both_is_store: got no write of 12345678 to 0000024c expected one");
    end
  endtask

  task automatic test_reset_mid_refill();
    int guard;
    xlog.delete();
    rd_req = 1'b1; addr = 32'h0000_0060;
    guard = 0;
    while (xlog.size() < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_rd_req !== 1'b0 || miss_cnt !== 32'd0 || guard >= 200) begin
      fails++;
      $display("FAIL reset_mid_refill: got rd_req=%b cnt=%0d words=%0d expected rd_req=0 cnt=0 words=3",
               mem_rd_req, miss_cnt, xlog.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = 1'b0;
    reset_reference();
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h0000_0060, '0, "after_reset");
  endtask

  task automatic test_drop_request();
    int guard;
    build_expected(2'd3, 25'd7);
    xlog.delete();
    rd_req = 1'b1; addr = 32'h0000_03E4;
    #1;
    tests++;
    if (miss !== 1'b1) begin
      fails++;
      $display("FAIL drop_start_miss: got %b expected 1", miss);
    end
    repeat (4) @(negedge clk);
    rd_req = 1'b0;
    guard = 0;
    while (xlog.size() < exp_q.size() && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    ref_miss_cnt++;
    rv[3] = 1'b1; rtag[3] = 25'd7; rdty[3] = 1'b0;
    #1;
    tests++;
    if (miss_cnt !== 32'(ref_miss_cnt) || xlog.size() != exp_q.size() || mem_rd_req !== 1'b0) begin
      fails++;
      $display("FAIL drop_request: got cnt=%0d xfers=%0d rd_req=%b expected cnt=%0d xfers=%0d rd_req=0",
               miss_cnt, xlog.size(), mem_rd_req, ref_miss_cnt, exp_q.size());
    end
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h0000_03E4, '0, "drop_then_hit");
  endtask

  task automatic test_back_to_back();
    lat_target = 1;
    do_access(1'b0, 1'b1, 32'h0000_03E8, 32'hA5A5_0F0F, "b2b_store");
    do_access(1'b1, 1'b0, 32'h0000_0068, '0, "b2b_dirty_evict");
    do_access(1'b1, 1'b0, 32'h0000_03E8, '0, "b2b_reload");
    lat_target = 3;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 255)) << 2;
      op = $urandom_range(0, 2);
      lat_target = ($urandom_range(0, 1) == 0) ? 1 : 3;
      do_access(op != 1, op != 0, a, $urandom, $sformatf("rand%0d", n));
    end
    lat_target = 3;
  endtask

  initial begin
    test_reset();
    test_refill_and_hit();
    test_dirty_evict();
    test_clean_evict();
    test_read_write_both();
    test_reset_mid_refill();
    test_drop_request();
    test_back_to_back();
    test_random();
    tests++;
    if (both_req_seen != 0) begin
      fails++;
      $display("FAIL mem_req_exclusive: got %0d overlapping cycles expected 0", both_req_seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
